poly_alu_seq: RTL

- Issue/writeback sequencer that sits directly upstream and downstream of the polynomial ALU datapath.
- On start, it streams all N_COEF coefficient tuples out of coefficient RAM into the ALU, holding the ALU mode word constant for the whole pass.
- It captures each ALU result pair on the ALU valid strobe and writes it back to RAM at the matching address.
- It is the unit the top-level Dilithium controller invokes for one pointwise/butterfly pass.

---
 rtl/poly_alu_seq.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/poly_alu_seq.sv
// Issue/writeback sequencer for one polynomial ALU pass: streams N_COEF RAM tuples
// through the fixed-latency ALU and writes each result pair back to its source address.
module poly_alu_seq #(
  parameter int N_COEF  = 256,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 24,
  parameter int RD_LAT  = 1,
  parameter int ALU_LAT = 5
) (
  input  logic              poly_clk,
  input  logic              poly_rst,
  input  logic              start,
  input  logic              pause,
  input  logic [9:0]        op_mode,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data0,
  input  logic [DATA_W-1:0] rd_data1,
  input  logic [DATA_W-1:0] rd_data2,
  input  logic [DATA_W-1:0] rd_data3,
  output logic              alu_enable,
  output logic [9:0]        alu_mode,
  output logic [DATA_W-1:0] alu_din0,
  output logic [DATA_W-1:0] alu_din1,
  output logic [DATA_W-1:0] alu_din2,
  output logic [DATA_W-1:0] alu_din3,
  input  logic              alu_valid,
  input  logic [DATA_W-1:0] alu_dout0,
  input  logic [DATA_W-1:0] alu_dout1,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data0,
  output logic [DATA_W-1:0] wr_data1
);

  localparam int TRK_D = RD_LAT + ALU_LAT;
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_COEF - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_FIN   = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0] wb_cnt_q, wb_cnt_d;
  logic [9:0]       mode_q, mode_d;
  logic             err_q, err_d;

  logic              en_dly_q [RD_LAT];
  logic              trk_v_q [TRK_D];
  logic [ADDR_W-1:0] trk_a_q [TRK_D];
  logic [DATA_W-1:0] rd_data_w [4];
  logic [DATA_W-1:0] din_hold_q [4];
  logic [DATA_W-1:0] alu_din_w [4];

  logic tail_v;
  logic wb_fire;
  logic spurious;

  assign rd_en   = (state_q == ST_ISSUE) && !pause;
  assign rd_addr = (state_q == ST_ISSUE) ? issue_cnt_q[ADDR_W-1:0] : '0;

  // Read-strobe delay line: alu_enable lines up with the cycle rd_data is valid.
  generate
    for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_en_dly
      if (gi == 0) begin : g_head
        always_ff @(posedge poly_clk) begin
          if (poly_rst) en_dly_q[gi] <= 1'b0;
          else          en_dly_q[gi] <= rd_en;
        end
      end else begin : g_body
        always_ff @(posedge poly_clk) begin
          if (poly_rst) en_dly_q[gi] <= 1'b0;
          else          en_dly_q[gi] <= en_dly_q[gi-1];
        end
      end
    end
  endgenerate

  assign alu_enable = en_dly_q[RD_LAT-1];

  assign rd_data_w[0] = rd_data0;
  assign rd_data_w[1] = rd_data1;
  assign rd_data_w[2] = rd_data2;
  assign rd_data_w[3] = rd_data3;

  // Operands follow rd_data while enabled and freeze on the last captured tuple otherwise.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_din
      always_ff @(posedge poly_clk) begin
        if (poly_rst)        din_hold_q[gi] <= '0;
        else if (alu_enable) din_hold_q[gi] <= rd_data_w[gi];
      end
      assign alu_din_w[gi] = alu_enable ? rd_data_w[gi] : din_hold_q[gi];
    end
  endgenerate

  assign alu_din0 = alu_din_w[0];
  assign alu_din1 = alu_din_w[1];
  assign alu_din2 = alu_din_w[2];
  assign alu_din3 = alu_din_w[3];

  // {valid, addr} tracker spanning RAM + ALU latency; its tail pairs with alu_valid.
  generate
    for (genvar gi = 0; gi < TRK_D; gi++) begin : g_trk
      if (gi == 0) begin : g_head
        always_ff @(posedge poly_clk) begin
          if (poly_rst) begin
            trk_v_q[gi] <= 1'b0;
            trk_a_q[gi] <= '0;
          end else begin
            trk_v_q[gi] <= rd_en;
            trk_a_q[gi] <= rd_addr;
          end
        end
      end else begin : g_body
        always_ff @(posedge poly_clk) begin
          if (poly_rst) begin
            trk_v_q[gi] <= 1'b0;
            trk_a_q[gi] <= '0;
          end else begin
            trk_v_q[gi] <= trk_v_q[gi-1];
            trk_a_q[gi] <= trk_a_q[gi-1];
          end
        end
      end
    end
  endgenerate

  assign tail_v   = trk_v_q[TRK_D-1];
  assign wb_fire  = alu_valid && tail_v;
  assign spurious = alu_valid && !tail_v;

  assign wr_en    = wb_fire;
  assign wr_addr  = wb_fire ? trk_a_q[TRK_D-1] : '0;
  assign wr_data0 = wb_fire ? alu_dout0 : '0;
  assign wr_data1 = wb_fire ? alu_dout1 : '0;

  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    wb_cnt_d    = wb_cnt_q;
    mode_d      = mode_q;
    err_d       = err_q;
    if (spurious) err_d = 1'b1;
    if (wb_fire)  wb_cnt_d = wb_cnt_q + CNT_W'(1);
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d      = op_mode;
          err_d       = 1'b0;
          issue_cnt_d = '0;
          wb_cnt_d    = '0;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!pause) begin
          issue_cnt_d = issue_cnt_q + CNT_W'(1);
          if (issue_cnt_q == LAST_IDX) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (wb_fire && (wb_cnt_q == LAST_IDX)) state_d = ST_FIN;
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge poly_clk) begin
    if (poly_rst) begin
      state_q     <= ST_IDLE;
      issue_cnt_q <= '0;
      wb_cnt_q    <= '0;
      mode_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      wb_cnt_q    <= wb_cnt_d;
      mode_q      <= mode_d;
      err_q       <= err_d;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_FIN);
  assign err      = err_q;
  assign alu_mode = mode_q;

endmodule
